// File: rtl/sh4a_decode_q.sv
// SH-4A decode stage: combinational decode of a supported opcode subset into a
// flushable FIFO of decoded entries. Privileged ops are enabled by SH4A_DECODE_PRIV_EN.
module sh4a_decode_q #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int IMM_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       md,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                insn,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       insn_valid,
    output logic                       insn_privileged,
    output logic                       src1_valid,
    output logic                       src2_valid,
    output logic                       dest_valid,
    output logic                       imm_valid,
    output logic [3:0]                 src1_reg,
    output logic [3:0]                 src2_reg,
    output logic [3:0]                 dest_reg,
    output logic [IMM_W-1:0]           imm,
    output logic [5:0]                 op,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [5:0] OP_NO_OP   = 6'd0;
    localparam logic [5:0] OP_MULTIPLY = 6'd1;
    localparam logic [5:0] OP_ADD     = 6'd2;
    localparam logic [5:0] OP_MOV     = 6'd3;
    localparam logic [5:0] OP_ILLEGAL = 6'd63;
`ifdef SH4A_DECODE_PRIV_EN
    localparam logic [5:0] OP_LDC_SR  = 6'd4;
    localparam logic [5:0] OP_STC_SR  = 6'd5;
    localparam logic [5:0] OP_RTE     = 6'd6;
`endif

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [5:0]       op;
        logic [IMM_W-1:0] imm;
        logic [3:0]       src1_reg;
        logic [3:0]       src2_reg;
        logic [3:0]       dest_reg;
        logic             insn_valid;
        logic             insn_privileged;
        logic             src1_valid;
        logic             src2_valid;
        logic             dest_valid;
        logic             imm_valid;
    } entry_t;

    entry_t          dec;
    entry_t          head;
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop;

    wire [3:0]       rn        = insn[11:8];
    wire [3:0]       rm        = insn[7:4];
    wire [IMM_W-1:0] imm_sext  = {{(IMM_W-8){insn[7]}}, insn[7:0]};

`ifndef SH4A_DECODE_PRIV_EN
    logic unused_md;
    assign unused_md = md;
`endif

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch is inferred on paths that skip an assignment.
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        dec.op = OP_ILLEGAL;
        if (insn == 16'h0009) begin
            dec.op         = OP_NO_OP;
            dec.insn_valid = 1'b1;
        end else if (insn[15:12] == 4'h0 && insn[3:0] == 4'h7) begin
            dec.op = OP_MULTIPLY;
            dec.insn_valid = 1'b1;
            dec.src1_valid = 1'b1; dec.src1_reg = rn;
            dec.src2_valid = 1'b1; dec.src2_reg = rm;
        end else if (insn[15:12] == 4'h3 && insn[3:0] == 4'hC) begin
            dec.op = OP_ADD;
            dec.insn_valid = 1'b1;
            dec.src1_valid = 1'b1; dec.src1_reg = rn;
            dec.src2_valid = 1'b1; dec.src2_reg = rm;
            dec.dest_valid = 1'b1; dec.dest_reg = rn;
        end else if (insn[15:12] == 4'h7) begin
            dec.op = OP_ADD;
            dec.insn_valid = 1'b1;
            dec.src1_valid = 1'b1; dec.src1_reg = rn;
            dec.dest_valid = 1'b1; dec.dest_reg = rn;
            dec.imm_valid  = 1'b1; dec.imm      = imm_sext;
        end else if (insn[15:12] == 4'h6 && insn[3:0] == 4'h3) begin
            dec.op = OP_MOV;
            dec.insn_valid = 1'b1;
            dec.src1_valid = 1'b1; dec.src1_reg = rm;
            dec.dest_valid = 1'b1; dec.dest_reg = rn;
        end else if (insn[15:12] == 4'hE) begin
            dec.op = OP_MOV;
            dec.insn_valid = 1'b1;
            dec.dest_valid = 1'b1; dec.dest_reg = rn;
            dec.imm_valid  = 1'b1; dec.imm      = imm_sext;
`ifdef SH4A_DECODE_PRIV_EN
        // In user mode a privileged word stays ILLEGAL but keeps the privileged flag.
        end else if (insn[15:12] == 4'h4 && insn[7:0] == 8'h0E) begin
            dec.insn_privileged = 1'b1;
            if (md) begin
                dec.op = OP_LDC_SR;
                dec.insn_valid = 1'b1;
                dec.src1_valid = 1'b1; dec.src1_reg = rn;
            end
        end else if (insn[15:12] == 4'h0 && insn[7:0] == 8'h02) begin
            dec.insn_privileged = 1'b1;
            if (md) begin
                dec.op = OP_STC_SR;
                dec.insn_valid = 1'b1;
                dec.dest_valid = 1'b1; dec.dest_reg = rn;
            end
        end else if (insn == 16'h002B) begin
            dec.insn_privileged = 1'b1;
            if (md) begin
                dec.op = OP_RTE;
                dec.insn_valid = 1'b1;
            end
`endif
        end
    end

    assign in_ready  = (level_q < LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; stale contents are
    // never visible because the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= dec;
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign insn_valid      = head.insn_valid;
    assign insn_privileged = head.insn_privileged;
    assign src1_valid      = head.src1_valid;
    assign src2_valid      = head.src2_valid;
    assign dest_valid      = head.dest_valid;
    assign imm_valid       = head.imm_valid;
    assign src1_reg        = head.src1_reg;
    assign src2_reg        = head.src2_reg;
    assign dest_reg        = head.dest_reg;
    assign imm             = head.imm;
    assign op              = head.op;
    assign out_pc          = head.pc;
    assign level           = level_q;

endmodule

// File: tb/tb_sh4a_decode_q.sv
// Directed and randomized self-checking bench for sh4a_decode_q (DEPTH=4, 32-bit PC/imm).
// Privileged-group expectations follow SH4A_DECODE_PRIV_EN when defined.
module tb_sh4a_decode_q;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int IMM_W = 32;

    logic        clk = 1'b0;
    logic        rst, flush, md, in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] insn;
    logic [31:0] in_pc;
    logic        insn_valid, insn_privileged, src1_valid, src2_valid, dest_valid, imm_valid;
    logic [3:0]  src1_reg, src2_reg, dest_reg;
    logic [31:0] imm, out_pc;
    logic [5:0]  op;
    logic [2:0]  level;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [15:0] w;
    } item_t;
    item_t q[$];

    sh4a_decode_q #(.DEPTH(DEPTH), .PC_W(PC_W), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .md(md),
        .in_valid(in_valid), .in_ready(in_ready), .insn(insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .insn_valid(insn_valid), .insn_privileged(insn_privileged),
        .src1_valid(src1_valid), .src2_valid(src2_valid),
        .dest_valid(dest_valid), .imm_valid(imm_valid),
        .src1_reg(src1_reg), .src2_reg(src2_reg), .dest_reg(dest_reg),
        .imm(imm), .op(op), .out_pc(out_pc), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags order: {insn_valid, insn_privileged, src1_valid, src2_valid, dest_valid, imm_valid}
    task automatic chk_head(input string tag, input logic [5:0] e_op, input logic [5:0] e_fl,
                            input logic [3:0] e_s1, input logic [3:0] e_s2, input logic [3:0] e_d,
                            input logic [31:0] e_imm, input logic [31:0] e_pc);
        check({tag, ".op"}, op, e_op);
        check({tag, ".flags"},
              {insn_valid, insn_privileged, src1_valid, src2_valid, dest_valid, imm_valid}, e_fl);
        check({tag, ".regs"}, {src1_reg, src2_reg, dest_reg}, {e_s1, e_s2, e_d});
        check({tag, ".imm"}, imm, e_imm);
        check({tag, ".pc"}, out_pc, e_pc);
    endtask

    // Push one word into an empty queue, check the head, then pop it.
    task automatic single(input string tag, input logic [15:0] w, input logic m,
                          input logic [5:0] e_op, input logic [5:0] e_fl,
                          input logic [3:0] e_s1, input logic [3:0] e_s2, input logic [3:0] e_d,
                          input logic [31:0] e_imm);
        out_ready = 1'b0;
        md = m; insn = w; in_pc = {16'h4000, w}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_head(tag, e_op, e_fl, e_s1, e_s2, e_d, e_imm, {16'h4000, w});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".drained"}, level, 0);
    endtask

    initial begin
        logic        accepted, popped, stalled;
        logic [31:0] prev_pc, prev_imm, e_imm;
        int          guard;

        rst = 1'b1; flush = 1'b0; md = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        insn = 16'h0; in_pc = 32'h0;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.level", level, 0);
        chk_head("rst", 6'd0, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0);

        // mul.l R2,R1 with immediate consumption
        out_ready = 1'b1; insn = 16'h0127; in_pc = 32'h8C00_0000; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mul.valid", out_valid, 1);
        chk_head("mul", 6'd1, 6'b101100, 4'd1, 4'd2, 4'd0, 32'h0, 32'h8C00_0000);
        step();
        check("mul.level_after", level, 0);
        check("mul.out_valid_after", out_valid, 0);

        // Sign-extended immediates, two entries queued
        out_ready = 1'b0;
        insn = 16'h7380; in_pc = 32'h100; in_valid = 1'b1;
        step();
        insn = 16'hE5FF; in_pc = 32'h102;
        step();
        in_valid = 1'b0;
        check("imm.level", level, 2);
        chk_head("addi", 6'd2, 6'b101011, 4'd3, 4'd0, 4'd3, 32'hFFFF_FF80, 32'h100);
        out_ready = 1'b1;
        step();
        chk_head("movi", 6'd3, 6'b100011, 4'd0, 4'd0, 4'd5, 32'hFFFF_FFFF, 32'h102);
        step();
        check("imm.drained", level, 0);
        out_ready = 1'b0;

        // Fill to DEPTH, then offer one more word while stalled
        for (int i = 0; i <= DEPTH; i++) begin
            insn = {4'h3, 4'(i), 4'(i + 1), 4'hC};
            in_pc = 32'h1000 + 32'(2 * i);
            in_valid = 1'b1;
            if (i < DEPTH) begin
                check("fill.in_ready", in_ready, 1);
                step();
            end
        end
        check("full.level", level, DEPTH);
        check("full.in_ready", in_ready, 0);
        step();
        check("full.hold_level", level, DEPTH);
        chk_head("full.head", 6'd2, 6'b101110, 4'd0, 4'd1, 4'd0, 32'h0, 32'h1000);
        out_ready = 1'b1;
        step();
        check("full.pop1_level", level, DEPTH - 1);
        check("full.pop1_in_ready", in_ready, 1);
        check("full.pop1_pc", out_pc, 32'h1002);
        step();
        in_valid = 1'b0;
        check("full.extra_level", level, DEPTH - 1);
        check("full.pc2", out_pc, 32'h1004);
        step();
        check("full.pc3", out_pc, 32'h1006);
        step();
        chk_head("full.extra", 6'd2, 6'b101110, 4'd4, 4'd5, 4'd4, 32'h0, 32'h1008);
        step();
        check("full.drained", level, 0);
        out_ready = 1'b0;

        // Flush with a word presented in the same cycle
        for (int i = 0; i < 3; i++) begin
            insn = 16'h0009; in_pc = 32'h3000 + 32'(i); in_valid = 1'b1;
            step();
        end
        check("flush.pre_level", level, 3);
        insn = 16'h6123; in_pc = 32'h3FFF; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.out_valid", out_valid, 0);
        check("flush.level", level, 0);
        check("flush.in_ready", in_ready, 1);
        chk_head("flush.fields", 6'd0, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0);
        step();
        check("flush.stays_empty", level, 0);
        single("mov_rr", 16'h6123, 1'b1, 6'd3, 6'b101010, 4'd2, 4'd0, 4'd1, 32'h0);
        single("nop", 16'h0009, 1'b1, 6'd0, 6'b100000, 4'd0, 4'd0, 4'd0, 32'h0);
        single("illegal", 16'hFFFD, 1'b1, 6'd63, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h0);

`ifdef SH4A_DECODE_PRIV_EN
        single("rte.md1", 16'h002B, 1'b1, 6'd6, 6'b110000, 4'd0, 4'd0, 4'd0, 32'h0);
        single("rte.md0", 16'h002B, 1'b0, 6'd63, 6'b010000, 4'd0, 4'd0, 4'd0, 32'h0);
        single("ldc.md1", 16'h430E, 1'b1, 6'd4, 6'b111000, 4'd3, 4'd0, 4'd0, 32'h0);
        single("stc.md1", 16'h0502, 1'b1, 6'd5, 6'b110010, 4'd0, 4'd0, 4'd5, 32'h0);
        single("stc.md0", 16'h0502, 1'b0, 6'd63, 6'b010000, 4'd0, 4'd0, 4'd0, 32'h0);
`else
        single("rte.nopriv", 16'h002B, 1'b1, 6'd63, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h0);
        single("ldc.nopriv", 16'h430E, 1'b1, 6'd63, 6'b000000, 4'd0, 4'd0, 4'd0, 32'h0);
`endif

        // Random pushes/pops against a reference FIFO of mov #i,Rn words
        md = 1'b1; in_valid = 1'b0; accepted = 1'b0; stalled = 1'b0;
        prev_pc = '0; prev_imm = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || accepted) begin
                in_valid = 1'($urandom_range(0, 1));
                insn = 16'hE000 | 16'($urandom_range(0, 4095));
                in_pc = $urandom;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            check("rnd.level", level, q.size());
            check("rnd.in_ready", in_ready, q.size() < DEPTH);
            check("rnd.out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                e_imm = {{24{q[0].w[7]}}, q[0].w[7:0]};
                check("rnd.pc", out_pc, q[0].pc);
                check("rnd.imm", imm, e_imm);
                check("rnd.dest", {op, dest_reg}, {6'd3, q[0].w[11:8]});
            end else begin
                check("rnd.empty_pc", out_pc, 0);
            end
            if (stalled) begin
                check("rnd.stall_pc", out_pc, prev_pc);
                check("rnd.stall_imm", imm, prev_imm);
            end
            accepted = in_valid && (q.size() < DEPTH);
            popped   = (q.size() != 0) && out_ready;
            stalled  = (q.size() != 0) && !out_ready;
            prev_pc  = out_pc;
            prev_imm = imm;
            step();
            if (popped) void'(q.pop_front());
            if (accepted) q.push_back('{pc: in_pc, w: insn});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (out_valid && guard < DEPTH + 2) begin
            step();
            guard++;
        end
        check("rnd.final_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
